seq_cmp: RTL

SEQ_CMP -- requirements
Module: seq_cmp

---
 rtl/seq_cmp.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seq_cmp.sv
// ============================================================================
// seq_cmp
//
// Multi-cycle magnitude comparator. A start pulse captures two WIDTH-bit
// operands and a signedness flag. The operands are then compared CHUNK bits
// per cycle, starting with the most significant chunk. The compare stops at
// the first chunk where the operands differ. The less/equal result is held
// until the next decision, so it can feed the branch-condition decoder
// directly.
//
// Parameters
//   WIDTH    operand width in bits (must be an integer multiple of CHUNK)
//   CHUNK    bits compared per cycle
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request pulse; accepted in IDLE or DONE, ignored in CMP
//   sgn      1 = two's-complement compare, 0 = unsigned (captured with start)
//   a_in     left operand (captured with start)
//   b_in     right operand (captured with start)
//   busy     high while a compare is in progress (state CMP)
//   done     one-cycle pulse; less_out/eql_out are valid
//   less_out a < b under the captured signedness
//   eql_out  a == b
// ============================================================================
module seq_cmp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             less_out,
    output logic             eql_out
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCH - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;

    logic capture;
    logic step;
    logic decide;
    logic dec_less;
    logic dec_eql;

    // The current chunk of each operand is picked with an explicit loop.
    // This keeps the index width independent of the product idx*CHUNK and
    // maps cleanly onto a mux for any NCH.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath controls.
    // start is ignored in CMP so the compare in flight cannot be disturbed.
    // In DONE, start begins the next compare in the same edge that retires
    // the current one.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        step      = 1'b0;
        decide    = 1'b0;
        dec_less  = 1'b0;
        dec_eql   = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = CMP;
                end
            end

            CMP: begin
                if (a_sl != b_sl) begin
                    decide    = 1'b1;
                    dec_less  = (a_sl < b_sl);
                    state_nxt = DONE;
                end else if (idx != '0) begin
                    step      = 1'b1;
                end else begin
                    decide    = 1'b1;
                    dec_eql   = 1'b1;
                    state_nxt = DONE;
                end
            end

            DONE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = CMP;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and chunk index.
    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order. After that, every chunk compare is a plain unsigned
    // compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            idx <= '0;
        end else if (capture) begin
            a_q <= a_in ^ (sgn ? MSB_MASK : '0);
            b_q <= b_in ^ (sgn ? MSB_MASK : '0);
            idx <= IDX_TOP;
        end else if (step) begin
            idx <= idx - IDXW'(1);
        end
    end

    // Result flags change only at a decision edge. The branch decoder
    // downstream sees a stable value for the whole compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            less_out <= 1'b0;
            eql_out  <= 1'b0;
        end else if (decide) begin
            less_out <= dec_less;
            eql_out  <= dec_eql;
        end
    end

    assign busy = (state == CMP);
    assign done = (state == DONE);

    // A decision can never report both less and equal.
    a_flags_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(less_out && eql_out)
    );

endmodule
